// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: hex decode, per-slot anti-ghost blanking and a
// frame-synchronous double buffer so displayed content only changes between frames.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 12500,
  parameter int BLANK          = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blank,
  input  logic                load,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   dig,
  output logic                frame_start
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  // XOR masks that turn an active-high pattern into pin levels.
  localparam logic [7:0]        SEG_OFF   = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF   = {DIGITS{DIG_ACTIVE_LOW}};

  if (DIGITS < 1 || DIGITS > 8 || DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_bad_params
    $error("seg7_scan_driver: illegal parameter set");
  end

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
  } frame_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_end;
  logic             frame_end;

  assign slot_end  = (div_cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  frame_t in_frame;
  frame_t shadow;
  frame_t active;
  logic   pending;

  assign in_frame = {value, dp, blank};

  // NOTE: shadow/active are plain registers, not RAM, so they take the async reset;
  // a display showing garbage after reset is a visible defect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (load && frame_end) begin
      // A load on the boundary edge bypasses the shadow and is shown next frame.
      active  <= in_frame;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= in_frame;
      pending <= 1'b1;
    end else if (frame_end && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  logic [3:0]        nibble;
  logic              lit;
  logic [7:0]        seg_ah;
  logic [DIGITS-1:0] dig_ah;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    seg_ah = '0;
    dig_ah = '0;
    nibble = active.value[4*int'(idx) +: 4];
    lit    = (div_cnt >= CNT_BLANK) && !active.blank[idx];
    if (lit) begin
      seg_ah      = {active.dp[idx], hex_to_seg(nibble)};
      dig_ah[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= SEG_OFF;
      dig         <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_ah ^ SEG_OFF;
      dig         <= dig_ah ^ DIG_OFF;
      frame_start <= (div_cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-clock slots, 2-clock blanking):
// a cycle-time reference model predicts pins, a monitor pops and compares each cycle.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_start;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blank(blank),
    .load(load), .seg(seg), .dig(dig), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: time is counted in cycles since reset release; the frame
  // and slot position come straight from that count.
  logic [7:0]  seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_bl;
  logic [15:0] s_val;
  logic [3:0]  s_dp, s_bl;
  logic        m_pend;
  int          cyc;
  logic [12:0] sb [$];

  task automatic model_reset();
    cyc = 0;
    m_val = '0; m_dp = '0; m_bl = '0;
    s_val = '0; s_dp = '0; s_bl = '0;
    m_pend = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle's inputs and predict the pins after the coming edge.
  task automatic apply(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    int         pos, id;
    logic       on;
    logic [7:0] pat;
    logic [3:0] dsel;
    load = ld; value = v; dp = d; blank = b;
    pos  = cyc % FRAME;
    id   = pos / DIV;
    on   = ((pos % DIV) >= BLANK) && !m_bl[id];
    pat  = seg_tab[m_val[4*id +: 4]];
    pat[7] = m_dp[id];
    dsel = 4'b0001 << id;
    sb.push_back({(pos == 0), (on ? ~dsel : 4'hF), (on ? ~pat : 8'hFF)});
    if (ld && pos == FRAME - 1) begin
      m_val = v; m_dp = d; m_bl = b; m_pend = 1'b0;
    end else if (ld) begin
      s_val = v; s_dp = d; s_bl = b; m_pend = 1'b1;
    end else if (pos == FRAME - 1 && m_pend) begin
      m_val = s_val; m_dp = s_dp; m_bl = s_bl; m_pend = 1'b0;
    end
    cyc++;
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    apply(ld, v, d, b);
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic run_to(input int target);
    while (cyc < target) idle();
  endtask

  task automatic spot(input string nm, input logic [7:0] s, input logic [3:0] d);
    @(posedge clk);
    #2;
    check({nm, "_seg"}, 32'(seg), 32'(s));
    check({nm, "_dig"}, 32'(dig), 32'(d));
  endtask

  task automatic spot_at(input int at, input string nm, input logic [7:0] s, input logic [3:0] d);
    run_to(at);
    idle();
    spot(nm, s, d);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom),
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
    end
  endtask

  // Monitor: per-cycle scoreboard compare plus pin-level invariants.
  initial begin
    logic [12:0] e;
    forever begin
      @(posedge clk);
      #1;
      check("one_digit_max", 32'($countones(~dig) <= 1), 32'd1);
      if (dig == 4'hF) check("seg_dark_when_no_digit", 32'(seg), 32'hFF);
      if (rst_n) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check("pins{fs,dig,seg}", 32'({frame_start, dig, seg}), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load = 1'b0; value = '0; dp = '0; blank = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_dig", 32'(dig), 32'hF);
    check("reset_fs", 32'(frame_start), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 16'h0, 4'h0, 4'h0);

    // Load mid-frame 0; frame 0 still shows the reset content (all zeros).
    spot_at(2, "pre_load_d0", 8'hC0, 4'hE);
    run_to(5);
    step(1'b1, 16'h4321, 4'h0, 4'h0);
    spot_at(10, "pre_load_d1", 8'hC0, 4'hD);
    spot_at(33, "d0_blanking", 8'hFF, 4'hF);
    spot_at(34, "d0_shows_1", 8'hF9, 4'hE);

    // Digit 2 = A with its dp, shown in frame 2.
    run_to(40);
    step(1'b1, 16'h0A00, 4'b0100, 4'h0);
    // Digit 1 blanked, shown in frame 3 (pending while frame 2 is displayed).
    run_to(70);
    step(1'b1, 16'h1234, 4'h0, 4'b0010);
    spot_at(82, "d2_A_dp", 8'h08, 4'hB);
    spot_at(98, "d0_shows_4", 8'h99, 4'hE);
    spot_at(106, "d1_blanked", 8'hFF, 4'hF);

    // Two mid-frame loads, then a load on the boundary edge: only the last shows.
    run_to(110);
    step(1'b1, 16'h9999, 4'h0, 4'h0);
    run_to(113);
    step(1'b1, 16'hBBBB, 4'hF, 4'h0);
    run_to(127);
    step(1'b1, 16'h5678, 4'h0, 4'h0);
    spot_at(130, "d0_boundary_load", 8'h80, 4'hE);
    spot_at(154, "d3_boundary_load", 8'h92, 4'h7);

    random_cycles(800);

    // Pending load, then reset in the middle of digit 2's slot.
    while (cyc % FRAME != 12) idle();
    step(1'b1, 16'hFFFF, 4'hF, 4'h0);
    while (cyc % FRAME != 20) idle();
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_seg", 32'(seg), 32'hFF);
    check("midreset_dig", 32'(dig), 32'hF);
    check("midreset_fs", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(1'b0, 16'h0, 4'h0, 4'h0);
    spot_at(34, "post_reset_pending_dropped", 8'hC0, 4'hE);

    random_cycles(300);
    @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
